// File: rtl/reaction_timer_multi_pkg.sv
// Shared types and constants for the reaction timer: FSM state encoding,
// BCD digit width and small elaboration-time helpers.
package reaction_timer_multi_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_GO   = 3'd2,
        ST_DONE = 3'd3,
        ST_FOUL = 3'd4
    } state_e;

    function automatic int win_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Maximal-length Fibonacci tap masks (bit k set = stage k+1 feeds back).
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

endpackage

// File: rtl/reaction_timer_multi_if.sv
// Player-facing signal bundle of the reaction timer plus a debug view of the FSM.
interface reaction_timer_multi_if
    import reaction_timer_multi_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int N_DIGITS  = 4
);
    localparam int WIN_W  = win_width(N_PLAYERS);
    localparam int TIME_W = BCD_W * N_DIGITS;

    // No valid/ready here: start, btn are levels acted on at their rising edge,
    // hs_clear is a one-cycle pulse, new_best is a one-cycle pulse, the rest are levels.
    logic              start;
    logic [N_PLAYERS-1:0] btn;
    logic              hs_clear;
    logic              stim_led;
    logic [TIME_W-1:0] bcd_time;
    logic [TIME_W-1:0] bcd_best;
    logic [WIN_W-1:0]  winner;
    logic              foul;
    logic              overflow;
    logic              new_best;
    state_e            dbg_state;

    modport master (
        output start, btn, hs_clear,
        input  stim_led, bcd_time, bcd_best, winner, foul, overflow, new_best, dbg_state
    );

    modport slave (
        input  start, btn, hs_clear,
        output stim_led, bcd_time, bcd_best, winner, foul, overflow, new_best, dbg_state
    );
endinterface

// File: rtl/reaction_timer_multi_bcd_counter.sv
// Multi-digit BCD up-counter with same-cycle carry ripple; holds at all-9s.
module bcd_counter
    import reaction_timer_multi_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      inc_i,
    output logic [BCD_W*N_DIGITS-1:0] value_o,
    output logic                      sat_o
);
    localparam logic [BCD_W*N_DIGITS-1:0] ALL9 = {N_DIGITS{4'h9}};

    logic [BCD_W*N_DIGITS-1:0] cnt_q, cnt_d;
    logic                      carry;

    assign value_o = cnt_q;
    assign sat_o   = (cnt_q == ALL9);

    always_comb begin
        cnt_d = cnt_q;
        carry = inc_i && !sat_o;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[BCD_W*i +: BCD_W] == 4'd9) begin
                    cnt_d[BCD_W*i +: BCD_W] = 4'd0;
                end else begin
                    cnt_d[BCD_W*i +: BCD_W] = cnt_q[BCD_W*i +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: random arm delay, stimulus lamp, BCD timing,
// foul detection and best-score tracking.
module reaction_timer_multi
    import reaction_timer_multi_pkg::*;
#(
    parameter int N_PLAYERS    = 2,
    parameter int N_DIGITS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int LFSR_W       = 12,
    parameter int MIN_DELAY_MS = 500
) (
    input logic                   clk,
    input logic                   reset,
    reaction_timer_multi_if.slave bus
);
    localparam int WIN_W  = win_width(N_PLAYERS);
    localparam int TIME_W = BCD_W * N_DIGITS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DLY_W  = $clog2(MIN_DELAY_MS + (1 << LFSR_W)) + 1;
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [TIME_W-1:0] ALL9 = {N_DIGITS{4'h9}};

    state_e               state_q, state_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic                 start_prev_q;
    logic [N_PLAYERS-1:0] btn_prev_q;
    logic [WIN_W-1:0]     winner_q, winner_d;
    logic                 overflow_q, overflow_d;
    logic [TIME_W-1:0]    best_q, best_d;
    logic                 new_best_q, new_best_d;

    logic                 tick;
    logic                 start_rise;
    logic [N_PLAYERS-1:0] btn_rise;
    logic [WIN_W-1:0]     first_idx;
    logic                 cnt_clr, cnt_inc;
    logic [TIME_W-1:0]    time_val;
    logic                 time_sat;

    assign start_rise = bus.start & ~start_prev_q;
    assign btn_rise   = bus.btn & ~btn_prev_q;
    assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign lfsr_d     = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};

    // Scan downward so the lowest-indexed pressing player is the final write.
    always_comb begin
        first_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (btn_rise[i]) begin
                first_idx = WIN_W'(i);
            end
        end
    end

    bcd_counter #(.N_DIGITS(N_DIGITS)) u_time (
        .clk    (clk),
        .rst    (reset),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .value_o(time_val),
        .sat_o  (time_sat)
    );

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        winner_d   = winner_q;
        overflow_d = overflow_q;
        best_d     = best_q;
        new_best_d = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FOUL: begin
                if (start_rise) begin
                    state_d    = ST_ARM;
                    dly_d      = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q);
                    cnt_clr    = 1'b1;
                    overflow_d = 1'b0;
                    winner_d   = '0;
                end
            end
            ST_ARM: begin
                if (|btn_rise) begin
                    state_d  = ST_FOUL;
                    winner_d = first_idx;
                end else if (tick) begin
                    if (dly_q <= DLY_W'(1)) begin
                        state_d = ST_GO;
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
            end
            ST_GO: begin
                // A press beats a coincident tick, so the final time excludes it.
                if (|btn_rise) begin
                    state_d  = ST_DONE;
                    winner_d = first_idx;
                    if ((time_val < best_q) || (best_q == ALL9)) begin
                        best_d     = time_val;
                        new_best_d = 1'b1;
                    end
                end else if (tick) begin
                    if (time_sat) begin
                        state_d    = ST_DONE;
                        overflow_d = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.hs_clear) begin
            best_d     = ALL9;
            new_best_d = 1'b0;
        end
    end

    // Divider restarts on every state entry so each phase begins on a full ms.
    assign tick_cnt_d = ((state_d != state_q) || tick) ? '0 : tick_cnt_q + TICK_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= LFSR_W'(1);
            tick_cnt_q   <= '0;
            dly_q        <= '0;
            start_prev_q <= 1'b0;
            btn_prev_q   <= '0;
            winner_q     <= '0;
            overflow_q   <= 1'b0;
            best_q       <= ALL9;
            new_best_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            tick_cnt_q   <= tick_cnt_d;
            dly_q        <= dly_d;
            start_prev_q <= bus.start;
            btn_prev_q   <= bus.btn;
            winner_q     <= winner_d;
            overflow_q   <= overflow_d;
            best_q       <= best_d;
            new_best_q   <= new_best_d;
        end
    end

    assign bus.stim_led  = (state_q == ST_GO);
    assign bus.foul      = (state_q == ST_FOUL);
    assign bus.bcd_time  = time_val;
    assign bus.bcd_best  = best_q;
    assign bus.winner    = winner_q;
    assign bus.overflow  = overflow_q;
    assign bus.new_best  = new_best_q;
    assign bus.dbg_state = state_q;
endmodule
